// File: rtl/dso_trigger_detector.sv
// dso_trigger_detector: level/edge trigger for the DSO ADC stream.
// Two-stage pipeline (sample register, then compare/FSM) with a registered
// one-cycle trigger_req, programmable hysteresis re-arm and holdoff.
// Optional auto-trigger timeout is built when DSO_TRIG_AUTO_EN is defined.
module dso_trigger_detector #(
    parameter int DATA_W = 8,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              enable,
    input  logic              edge_sel,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hysteresis,
    input  logic [HOLD_W-1:0] holdoff,
`ifdef DSO_TRIG_AUTO_EN
    input  logic [HOLD_W-1:0] auto_timeout,
    output logic              auto_fired,
`endif
    output logic              trigger_req,
    output logic              armed,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        ARMED   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              s_vld_q, s_vld_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              trig_q, trig_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    logic [DATA_W-1:0] hyst_q, hyst_d;
    logic              edge_q, edge_d;

    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] arm_th;
    logic              arm_ok;
    logic              fire_ok;
    logic              timeout_hit;

    // Stage 1: capture the strobed sample; s_vld is a one-cycle echo of sample_en.
    always_comb begin
        s_d     = sample_en ? adc_data : s_q;
        s_vld_d = sample_en;
    end

    // Saturating arm threshold and arm/fire tests from the latched config.
    assign sum_w = {1'b0, lvl_q} + {1'b0, hyst_q};
    always_comb begin
        if (edge_q) begin
            arm_th  = sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
            arm_ok  = (s_q >= arm_th);
            fire_ok = (s_q <= lvl_q);
        end else begin
            arm_th  = (lvl_q >= hyst_q) ? (lvl_q - hyst_q) : '0;
            arm_ok  = (s_q <= arm_th);
            fire_ok = (s_q >= lvl_q);
        end
    end

    // Next-state logic; enable low wins over everything, including a fire.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        trig_d     = 1'b0;
        lvl_d      = lvl_q;
        hyst_d     = hyst_q;
        edge_d     = edge_q;
        if (!enable) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Config is frozen here for the whole run.
                    state_d = ARMING;
                    lvl_d   = level;
                    hyst_d  = hysteresis;
                    edge_d  = edge_sel;
                end
                ARMING: begin
                    if (s_vld_q) begin
                        if (timeout_hit) begin
                            state_d    = HOLDOFF;
                            hold_cnt_d = holdoff;
                            trig_d     = 1'b1;
                        end else if (arm_ok) begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (s_vld_q && (fire_ok || timeout_hit)) begin
                        state_d    = HOLDOFF;
                        hold_cnt_d = holdoff;
                        trig_d     = 1'b1;
                    end
                end
                HOLDOFF: begin
                    // The firing sample went to HOLDOFF, so it can never re-arm.
                    if (s_vld_q) begin
                        if (hold_cnt_q == '0) state_d = ARMING;
                        else                  hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef DSO_TRIG_AUTO_EN
    logic [HOLD_W-1:0] to_cnt_q, to_cnt_d;
    logic              auto_q, auto_d;

    // Timeout counter: strobes spent waiting in ARMING/ARMED, cleared on fresh entry to ARMING.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d == IDLE || (state_d == ARMING && state_q != ARMING))
            to_cnt_d = '0;
        else if (s_vld_q && (state_q == ARMING || state_q == ARMED))
            to_cnt_d = to_cnt_q + 1'b1;
    end

    assign timeout_hit = (auto_timeout != '0) && ((to_cnt_q + 1'b1) == auto_timeout);

    // A trigger is "auto" unless a real fire condition produced it.
    always_comb begin
        auto_d = trig_d && !(state_q == ARMED && fire_ok);
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            auto_q   <= auto_d;
        end
    end

    assign auto_fired = auto_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // Main state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            s_vld_q    <= 1'b0;
            hold_cnt_q <= '0;
            trig_q     <= 1'b0;
            lvl_q      <= '0;
            hyst_q     <= '0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            s_vld_q    <= s_vld_d;
            hold_cnt_q <= hold_cnt_d;
            trig_q     <= trig_d;
            lvl_q      <= lvl_d;
            hyst_q     <= hyst_d;
            edge_q     <= edge_d;
        end
    end

    assign trigger_req = trig_q;
    assign armed       = (state_q == ARMED);
    assign state_out   = state_q;

endmodule

// File: tb/tb_dso_trigger_detector.sv
// Directed bench for dso_trigger_detector; optional auto-timeout section under DSO_TRIG_AUTO_EN.
module tb_dso_trigger_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        enable = 1'b0;
    logic        edge_sel = 1'b0;
    logic [7:0]  level = '0;
    logic [7:0]  hysteresis = '0;
    logic [15:0] holdoff = '0;
    logic        trigger_req;
    logic        armed;
    logic [1:0]  state_out;
`ifdef DSO_TRIG_AUTO_EN
    logic [15:0] auto_timeout = '0;
    logic        auto_fired;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    int   q_d[$];
    int   q_st[$];
    int   q_tr[$];
    logic q_en[$];

    always #5 clk = ~clk;

    dso_trigger_detector #(.DATA_W(8), .HOLD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .adc_data   (adc_data),
        .enable     (enable),
        .edge_sel   (edge_sel),
        .level      (level),
        .hysteresis (hysteresis),
        .holdoff    (holdoff),
`ifdef DSO_TRIG_AUTO_EN
        .auto_timeout (auto_timeout),
        .auto_fired   (auto_fired),
`endif
        .trigger_req(trigger_req),
        .armed      (armed),
        .state_out  (state_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Present one input cycle, then settle 1 time unit past the edge.
    task automatic step(input logic sen, input logic [7:0] d);
        sample_en = sen;
        adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Cycle enable to reload the latched config.
    task automatic restart(input logic es, input logic [7:0] lv, input logic [7:0] hy,
                           input logic [15:0] ho);
        enable = 1'b0;
        step(1'b0, 8'd0);
        chk("restart_idle", state_out, 0);
        edge_sel = es; level = lv; hysteresis = hy; holdoff = ho;
        enable = 1'b1;
        step(1'b0, 8'd0);
        chk("restart_arming", state_out, 1);
    endtask

    // After step i, outputs reflect evaluation of the sample from step i-1.
    task automatic run(input string tag);
        for (int i = 0; i < q_d.size(); i++) begin
            step(q_en[i], q_d[i][7:0]);
            chk($sformatf("%s_st[%0d]", tag, i), state_out, q_st[i]);
            chk($sformatf("%s_tr[%0d]", tag, i), trigger_req, q_tr[i]);
            chk($sformatf("%s_armed[%0d]", tag, i), armed, (q_st[i] == 2) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset
        step(1'b0, 8'd0);
        step(1'b1, 8'd200);
        chk("rst_state", state_out, 0);
        chk("rst_armed", armed, 0);
        chk("rst_trig", trigger_req, 0);
`ifdef DSO_TRIG_AUTO_EN
        chk("rst_auto", auto_fired, 0);
`endif
        rst = 1'b0;

        // Rising ramp, level 128 hyst 16; live config scrambled after latch.
        restart(1'b0, 8'd128, 8'd16, 16'd0);
        level = 8'd0; hysteresis = 8'd0; edge_sel = 1'b1;
        q_d  = '{100,110,120,130,140,150,160,170,180,190,200,0};
        q_en = '{1,1,1,1,1,1,1,1,1,1,1,0};
        q_st = '{1,2,2,2,3,1,1,1,1,1,1,1};
        q_tr = '{0,0,0,0,1,0,0,0,0,0,0,0};
        run("ramp");

        // Falling, level 64 hyst 8; repeated 60 gives no second pulse.
        restart(1'b1, 8'd64, 8'd8, 16'd0);
        q_d  = '{80,70,60,60,0,0};
        q_en = '{1,1,1,1,0,0};
        q_st = '{1,2,2,3,1,1};
        q_tr = '{0,0,0,1,0,0};
        run("fall");

        // Holdoff 3, square wave 0/255.
        restart(1'b0, 8'd128, 8'd10, 16'd3);
        q_d  = '{0,255,0,255,0,255,0,255,0,255,0,255,0,255};
        q_en = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1};
        q_st = '{1,2,3,3,3,3,1,2,3,3,3,3,1,2};
        q_tr = '{0,0,1,0,0,0,0,0,1,0,0,0,0,0};
        run("hold");

        // Saturation low: arm_th clamps to 0.
        restart(1'b0, 8'd5, 8'd20, 16'd0);
        q_d  = '{3,1,0,2,7,0,0};
        q_en = '{1,1,1,1,1,0,0};
        q_st = '{1,1,1,2,2,3,3};
        q_tr = '{0,0,0,0,0,1,0};
        run("satlo");

        // Saturation high: arm_th clamps to 255.
        restart(1'b1, 8'd250, 8'd20, 16'd0);
        q_d  = '{254,255,250,0,0};
        q_en = '{1,1,1,0,0};
        q_st = '{1,1,2,3,3};
        q_tr = '{0,0,0,1,0};
        run("sathi");

        // Drop enable with a fire sample in flight.
        restart(1'b0, 8'd128, 8'd16, 16'd0);
        step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        chk("en_armed_pre", armed, 1);
        enable = 1'b0;
        step(1'b0, 8'd0);
        chk("en_drop_state", state_out, 0);
        chk("en_drop_armed", armed, 0);
        chk("en_drop_trig", trigger_req, 0);
        step(1'b0, 8'd0);
        chk("en_drop_trig2", trigger_req, 0);

        // Reset with a fire sample in flight.
        enable = 1'b1;
        step(1'b0, 8'd0);
        step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        chk("rst_armed_pre", armed, 1);
        rst = 1'b1;
        step(1'b0, 8'd0);
        chk("rst_mid_state", state_out, 0);
        chk("rst_mid_armed", armed, 0);
        chk("rst_mid_trig", trigger_req, 0);
        rst = 1'b0;
        step(1'b0, 8'd0);
        chk("rst_after_trig", trigger_req, 0);
        chk("rst_after_state", state_out, 1);

`ifdef DSO_TRIG_AUTO_EN
        // Auto timeout 10 on a flat input that arms but never fires.
        auto_timeout = 16'd10;
        restart(1'b0, 8'd128, 8'd16, 16'd0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'd50);
            chk($sformatf("auto_st[%0d]", i), state_out,
                (i == 0) ? 1 : (i < 10) ? 2 : (i == 10) ? 3 : 1);
            chk($sformatf("auto_tr[%0d]", i), trigger_req, (i == 10) ? 1 : 0);
            chk($sformatf("auto_af[%0d]", i), auto_fired, (i == 10) ? 1 : 0);
        end
        auto_timeout = 16'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dso_trigger_detector.md
Name: dso_trigger_detector

Overview:
- Upstream neighbour of the ADC capture driver: watches the ADC sample stream and issues the one-cycle `trigger_req` pulse the capture driver consumes.
- Implements level/edge triggering with programmable hysteresis and a holdoff counter.
- All timing is in units of the capture sample strobe, so trigger decisions align with samples written to buffer memory.

Parameters:
- DATA_W, 8, ADC sample and threshold width (unsigned).
- HOLD_W, 16, width of holdoff (and auto-timeout) counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- sample_en  input  1  one-cycle strobe; adc_data is valid this cycle (same strobe that drives capture mem_en timing).
- adc_data  input  DATA_W  unsigned ADC sample.
- enable  input  1  1 = detector runs; 0 = forced to IDLE.
- edge_sel  input  1  0 = rising edge, 1 = falling edge.
- level  input  DATA_W  trigger threshold.
- hysteresis  input  DATA_W  re-arm distance from level.
- holdoff  input  HOLD_W  sample strobes to ignore after each trigger.
- trigger_req  output  1  one-cycle trigger pulse to the capture driver.
- armed  output  1  high in ARMED state.
- state_out  output  2  current state encoding, for status readback.

Behaviour:
- States: IDLE=0, ARMING=1, ARMED=2, HOLDOFF=3.
- Reset: state=IDLE; trigger_req=0; armed=0; state_out=0; sample register=0; sample-valid register=0; holdoff counter=0; latched config=0.
- Pipeline:
  - Stage 1: on sample_en, adc_data is registered into s_q and s_vld is set for one cycle.
  - Stage 2: the comparison uses s_q when s_vld=1.
  - trigger_req is registered. A sample presented with sample_en at cycle N produces trigger_req at cycle N+2. Fixed latency, no bypass.
- Config latch: level, hysteresis and edge_sel are latched on the IDLE->ARMING transition only. Changes while running take effect only after enable is cycled.
- Thresholds, unsigned and saturating, computed from latched config:
  - Rising: arm_th = level - hysteresis, clamped at 0. Arm condition s_q <= arm_th. Fire condition s_q >= level.
  - Falling: arm_th = level + hysteresis, clamped at 2^DATA_W-1. Arm condition s_q >= arm_th. Fire condition s_q <= level.
- Transitions (evaluated only when s_vld=1, except enable handling):
  - IDLE -> ARMING when enable=1 (no s_vld needed).
  - ARMING -> ARMED when the arm condition holds.
  - ARMED -> HOLDOFF when the fire condition holds; trigger_req=1 next cycle for exactly one cycle. Holdoff counter loads holdoff.
  - HOLDOFF: counter decrements on each s_vld. When the counter is 0 and s_vld=1, go to ARMING.
  - holdoff=0: leave HOLDOFF on the first s_vld after the trigger.
  - The sample that fires is never also used to arm.
- enable=0 in any state: next cycle is IDLE, the counter clears, and any pending trigger_req is suppressed. enable takes priority over a simultaneous fire condition.
- hysteresis=0 (rising): arm at s_q <= level and fire at s_q >= level, so the level value itself must be seen once as arming and a later sample fires.
- sample_en held high continuously is legal: every cycle is a sample.
- rst mid-operation returns all state to reset values on the next clock. No trigger_req is emitted on the cycle after a reset.

Optional Feature:
- Macro DSO_TRIG_AUTO_EN adds input auto_timeout [HOLD_W-1:0] and output auto_fired (1 bit).
- With the macro:
  - A timeout counter counts s_vld strobes while in ARMING or ARMED. It clears on entry to ARMING from IDLE or HOLDOFF.
  - When the count reaches auto_timeout (nonzero), a trigger_req is issued and the state goes to HOLDOFF as for a normal trigger. auto_fired=1 in the same cycle as that trigger_req.
  - auto_timeout=0 disables the timeout.
  - A real fire condition on the same sample as the timeout takes priority, with auto_fired=0.
- Without the macro: the ports are absent, no timeout logic is built, and the detector only triggers on edges.

Test Plan:
- Rising, level=128, hyst=16, holdoff=0, sample_en every cycle, ramp 100,110,...,200: armed rises after the sample 100 is evaluated; a single trigger_req arrives 2 cycles after sample 130 is presented.
- Falling, level=64, hyst=8, samples 80,70,60: arm on 80, trigger_req 2 cycles after sample 60; a repeated 60 gives no second pulse.
- Holdoff=3, square wave 0/255 every sample, rising, level=128, hyst=10: trigger pulses are separated by the 3 ignored strobes plus re-arm, and none occur inside holdoff.
- Saturation, rising, level=5, hyst=20: arm_th=0; arms only on sample 0 and fires on the next sample >=5. Falling, level=250, hyst=20: arm_th=255.
- Drop enable and assert rst during ARMED with a fire sample in flight: no trigger_req, state_out=0 next cycle, and armed=0.
- DSO_TRIG_AUTO_EN, auto_timeout=10, constant input 50: trigger_req with auto_fired=1 on the 10th strobe.
